// File: rtl/layer3_argmax_classifier.sv
// ---------------------------------------------------------------------------
// layer3_argmax_classifier
// Terminal stage of the ECG MLP datapath. Captures the ten layer-3 node
// outputs as one frame, scans them one element per cycle and reports the
// winning class, its activation, its margin over the runner-up and a
// no-detect flag when every activation is zero.
//
// Ports:
//   clk        system clock, rising edge
//   reset      synchronous active-high reset
//   N0x..N9x   layer-3 node outputs (unsigned, DW bits each)
//   in_valid   frame on N0x..N9x is valid
//   in_ready   block can accept a frame (combinational, high only in IDLE)
//   out_valid  result fields valid, held until consumed
//   out_ready  downstream consumes the result
//   class_idx  index of the maximum activation (lowest index on ties)
//   max_val    value of the maximum activation
//   margin     max_val minus the second-highest activation
//   no_detect  high when max_val == 0
// ---------------------------------------------------------------------------
module layer3_argmax_classifier #(
  parameter int unsigned N_IN = 10,
  parameter int unsigned DW   = 8,
  parameter int unsigned IDXW = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [DW-1:0]   N0x,
  input  logic [DW-1:0]   N1x,
  input  logic [DW-1:0]   N2x,
  input  logic [DW-1:0]   N3x,
  input  logic [DW-1:0]   N4x,
  input  logic [DW-1:0]   N5x,
  input  logic [DW-1:0]   N6x,
  input  logic [DW-1:0]   N7x,
  input  logic [DW-1:0]   N8x,
  input  logic [DW-1:0]   N9x,
  input  logic            in_valid,
  output logic            in_ready,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [IDXW-1:0] class_idx,
  output logic [DW-1:0]   max_val,
  output logic [DW-1:0]   margin,
  output logic            no_detect
);

  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(N_IN - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SCAN = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;

  logic [DW-1:0]   r_cap [N_IN];
  logic [IDXW-1:0] r_cnt;
  logic [DW-1:0]   r_best;
  logic [DW-1:0]   r_second;
  logic [IDXW-1:0] r_best_idx;

  logic            r_out_valid;
  logic [IDXW-1:0] r_class_idx;
  logic [DW-1:0]   r_max_val;
  logic [DW-1:0]   r_margin;
  logic            r_no_detect;

  logic [DW-1:0]   w_in [N_IN];
  logic            w_capture;
  logic            w_step;
  logic            w_last;
  logic            w_handshake;
  logic [DW-1:0]   w_x;
  logic [DW-1:0]   w_best_nxt;
  logic [DW-1:0]   w_second_nxt;
  logic [IDXW-1:0] w_idx_nxt;

  // Node outputs gathered into an indexable frame
  assign w_in[0] = N0x;
  assign w_in[1] = N1x;
  assign w_in[2] = N2x;
  assign w_in[3] = N3x;
  assign w_in[4] = N4x;
  assign w_in[5] = N5x;
  assign w_in[6] = N6x;
  assign w_in[7] = N7x;
  assign w_in[8] = N8x;
  assign w_in[9] = N9x;

  // State register
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (in_valid)                 w_state_nxt = S_SCAN;
      S_SCAN:  if (r_cnt == LAST_IDX)        w_state_nxt = S_DONE;
      S_DONE:  if (r_out_valid && out_ready) w_state_nxt = S_IDLE;
      default:                               w_state_nxt = S_IDLE;
    endcase
  end

  // Control decode
  always_comb begin
    in_ready    = (r_state == S_IDLE);
    w_capture   = (r_state == S_IDLE) && in_valid;
    w_step      = (r_state == S_SCAN);
    w_last      = (r_state == S_SCAN) && (r_cnt == LAST_IDX);
    w_handshake = r_out_valid && out_ready;
  end

  // Running top-two update; strict '>' keeps the lowest index on ties while
  // an equal value still lands in second, collapsing the margin to zero
  always_comb begin
    w_x          = r_cap[r_cnt];
    w_best_nxt   = r_best;
    w_second_nxt = r_second;
    w_idx_nxt    = r_best_idx;
    if (w_x > r_best) begin
      w_second_nxt = r_best;
      w_best_nxt   = w_x;
      w_idx_nxt    = r_cnt;
    end else if (w_x > r_second) begin
      w_second_nxt = w_x;
    end
  end

  // Frame capture and scan datapath
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < N_IN; i++) r_cap[i] <= '0;
      r_cnt      <= '0;
      r_best     <= '0;
      r_second   <= '0;
      r_best_idx <= '0;
    end else if (w_capture) begin
      for (int unsigned i = 0; i < N_IN; i++) r_cap[i] <= w_in[i];
      r_best     <= w_in[0];
      r_best_idx <= '0;
      r_second   <= '0;
      r_cnt      <= IDXW'(1);
    end else if (w_step) begin
      r_best     <= w_best_nxt;
      r_second   <= w_second_nxt;
      r_best_idx <= w_idx_nxt;
      r_cnt      <= w_last ? '0 : r_cnt + IDXW'(1);
    end
  end

  // Result registers, loaded from the final scan step so out_valid rises
  // the cycle the FSM enters DONE
  always_ff @(posedge clk) begin
    if (reset) begin
      r_out_valid <= 1'b0;
      r_class_idx <= '0;
      r_max_val   <= '0;
      r_margin    <= '0;
      r_no_detect <= 1'b0;
    end else if (w_last) begin
      r_out_valid <= 1'b1;
      r_class_idx <= w_idx_nxt;
      r_max_val   <= w_best_nxt;
      r_margin    <= w_best_nxt - w_second_nxt;
      r_no_detect <= (w_best_nxt == '0);
    end else if (w_handshake) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign class_idx = r_class_idx;
  assign max_val   = r_max_val;
  assign margin    = r_margin;
  assign no_detect = r_no_detect;

endmodule

// File: tb/tb_layer3_argmax_classifier.sv
// ---------------------------------------------------------------------------
// tb_layer3_argmax_classifier
// Self-checking bench: directed scenarios plus randomized frames compared
// against a two-pass reference model of the argmax / margin rules.
// ---------------------------------------------------------------------------
module tb_layer3_argmax_classifier;

  typedef logic [9:0][7:0] frame_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] n [10];
  logic       in_valid;
  logic       in_ready;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] class_idx;
  logic [7:0] max_val;
  logic [7:0] margin;
  logic       no_detect;

  int cyc = 0;
  int n_tests = 0;
  int n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  layer3_argmax_classifier dut (
    .clk       (clk),
    .reset     (reset),
    .N0x       (n[0]),
    .N1x       (n[1]),
    .N2x       (n[2]),
    .N3x       (n[3]),
    .N4x       (n[4]),
    .N5x       (n[5]),
    .N6x       (n[6]),
    .N7x       (n[7]),
    .N8x       (n[8]),
    .N9x       (n[9]),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .class_idx (class_idx),
    .max_val   (max_val),
    .margin    (margin),
    .no_detect (no_detect)
  );

  // Reference: winner = first occurrence of the maximum; runner-up = largest
  // value left after removing one copy of the maximum from the frame
  function automatic void ref_model(input frame_t f, output logic [3:0] idx,
                                    output logic [7:0] mx, output logic [7:0] mg,
                                    output logic nd);
    logic [7:0] sec;
    bit         removed;
    mx  = f[0];
    idx = 4'd0;
    for (int i = 1; i < 10; i++) begin
      if (f[i] > mx) begin
        mx  = f[i];
        idx = 4'(i);
      end
    end
    sec     = 8'd0;
    removed = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (!removed && f[i] == mx) removed = 1'b1;
      else if (f[i] > sec)        sec = f[i];
    end
    mg = mx - sec;
    nd = (mx == 8'd0);
  endfunction

  function automatic frame_t mk10(input int a0, input int a1, input int a2, input int a3,
                                  input int a4, input int a5, input int a6, input int a7,
                                  input int a8, input int a9);
    frame_t f;
    f[0] = 8'(a0); f[1] = 8'(a1); f[2] = 8'(a2); f[3] = 8'(a3); f[4] = 8'(a4);
    f[5] = 8'(a5); f[6] = 8'(a6); f[7] = 8'(a7); f[8] = 8'(a8); f[9] = 8'(a9);
    return f;
  endfunction

  function automatic frame_t rand_frame(input int hi);
    frame_t f;
    for (int i = 0; i < 10; i++) f[i] = 8'($urandom_range(0, hi));
    return f;
  endfunction

  task automatic drive_frame(input frame_t f);
    for (int i = 0; i < 10; i++) n[i] = f[i];
  endtask

  task automatic scramble();
    for (int i = 0; i < 10; i++) n[i] = 8'($urandom);
  endtask

  // Waits (bounded) for in_ready, presents one frame, then returns in the
  // first cycle out_valid is seen; lat counts cycles after capture (-1 = timeout)
  task automatic send_frame(input frame_t f, output int lat, output int cap_cyc);
    int g = 0;
    while (!in_ready && g < 50) begin
      @(posedge clk); #1;
      g++;
    end
    drive_frame(f);
    in_valid = 1'b1;
    @(posedge clk); #1;
    cap_cyc  = cyc;
    in_valid = 1'b0;
    scramble();
    lat = 1;
    while (!out_valid && lat < 30) begin
      @(posedge clk); #1;
      lat++;
      scramble();
    end
    if (!out_valid) lat = -1;
  endtask

  task automatic test_reset();
    int bad = 0;
    reset     = 1'b1;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    drive_frame(mk10(9, 8, 7, 6, 5, 4, 3, 2, 1, 200));
    repeat (3) @(posedge clk);
    #1;
    n_tests++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_hold: in_ready=%b out_valid=%b, required 1 0", in_ready, out_valid);
    end
    reset    = 1'b0;
    in_valid = 1'b0;
    n_tests++;
    if ({in_ready, out_valid, class_idx, max_val, margin, no_detect} !==
        {1'b1, 1'b0, 4'd0, 8'd0, 8'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_release: rdy=%b ov=%b idx=%0d max=%0d mg=%0d nd=%b, required 1 0 0 0 0 0",
               in_ready, out_valid, class_idx, max_val, margin, no_detect);
    end
    repeat (12) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) bad++;
    end
    n_tests++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL reset_no_capture: %0d idle cycles disturbed, required 0", bad);
    end
  endtask

  task automatic test_distinct();
    int lat, cc;
    out_ready = 1'b1;
    send_frame(mk10(3, 10, 7, 0, 2, 5, 1, 9, 4, 6), lat, cc);
    n_tests++;
    if (lat != 10) begin
      n_fail++;
      $display("FAIL distinct_latency: got %0d cycles, required 10", lat);
    end
    n_tests++;
    if ({class_idx, max_val, margin, no_detect} !== {4'd1, 8'd10, 8'd1, 1'b0}) begin
      n_fail++;
      $display("FAIL distinct_result: idx=%0d max=%0d mg=%0d nd=%b, required 1 10 1 0",
               class_idx, max_val, margin, no_detect);
    end
    @(posedge clk); #1;
    n_tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL distinct_ready_after: ov=%b rdy=%b, required 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_ties();
    int lat, cc;
    out_ready = 1'b1;
    send_frame(mk10(5, 20, 3, 20, 0, 0, 0, 0, 0, 0), lat, cc);
    n_tests++;
    if (lat != 10 || {class_idx, max_val, margin, no_detect} !== {4'd1, 8'd20, 8'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL tie_low_index: lat=%0d idx=%0d max=%0d mg=%0d nd=%b, required 10 1 20 0 0",
               lat, class_idx, max_val, margin, no_detect);
    end
    @(posedge clk); #1;
    send_frame(mk10(0, 0, 0, 0, 0, 0, 0, 0, 0, 127), lat, cc);
    n_tests++;
    if (lat != 10 || {class_idx, max_val, margin, no_detect} !== {4'd9, 8'd127, 8'd127, 1'b0}) begin
      n_fail++;
      $display("FAIL max_at_last: lat=%0d idx=%0d max=%0d mg=%0d nd=%b, required 10 9 127 127 0",
               lat, class_idx, max_val, margin, no_detect);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_all_zero();
    int lat, cc;
    out_ready = 1'b1;
    send_frame(mk10(0, 0, 0, 0, 0, 0, 0, 0, 0, 0), lat, cc);
    n_tests++;
    if (lat != 10 || {class_idx, max_val, margin, no_detect} !== {4'd0, 8'd0, 8'd0, 1'b1}) begin
      n_fail++;
      $display("FAIL all_zero: lat=%0d idx=%0d max=%0d mg=%0d nd=%b, required 10 0 0 0 1",
               lat, class_idx, max_val, margin, no_detect);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    int         lat, cc, hs, bad;
    frame_t     f, g;
    logic [3:0] ei;
    logic [7:0] em, eg;
    logic       en;
    out_ready = 1'b0;
    f = rand_frame(255);
    ref_model(f, ei, em, eg, en);
    send_frame(f, lat, cc);
    n_tests++;
    if (lat != 10 || {class_idx, max_val, margin, no_detect} !== {ei, em, eg, en}) begin
      n_fail++;
      $display("FAIL bp_result: lat=%0d idx=%0d max=%0d mg=%0d nd=%b, required 10 %0d %0d %0d %b",
               lat, class_idx, max_val, margin, no_detect, ei, em, eg, en);
    end
    bad = 0;
    for (int k = 0; k < 5; k++) begin
      scramble();
      in_valid = k[0] ? 1'b0 : 1'b1;
      @(posedge clk); #1;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 ||
          {class_idx, max_val, margin, no_detect} !== {ei, em, eg, en}) bad++;
    end
    n_tests++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL bp_stable: %0d unstable stall cycles, required 0", bad);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    hs = cyc;
    n_tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 ||
        {class_idx, max_val, margin, no_detect} !== {ei, em, eg, en}) begin
      n_fail++;
      $display("FAIL bp_handshake: ov=%b rdy=%b idx=%0d max=%0d, required 0 1 %0d %0d",
               out_valid, in_ready, class_idx, max_val, ei, em);
    end
    g = rand_frame(255);
    ref_model(g, ei, em, eg, en);
    send_frame(g, lat, cc);
    n_tests++;
    if (cc - hs != 1 || lat != 10 || {class_idx, max_val, margin, no_detect} !== {ei, em, eg, en}) begin
      n_fail++;
      $display("FAIL bp_next_frame: gap=%0d lat=%0d idx=%0d max=%0d mg=%0d, required 1 10 %0d %0d %0d",
               cc - hs, lat, class_idx, max_val, margin, ei, em, eg);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_scan();
    int lat, cc, bad;
    out_ready = 1'b1;
    drive_frame(mk10(1, 2, 3, 90, 5, 6, 7, 8, 9, 10));
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    n_tests++;
    if ({in_ready, out_valid, class_idx, max_val, margin, no_detect} !==
        {1'b1, 1'b0, 4'd0, 8'd0, 8'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL midscan_reset_state: rdy=%b ov=%b idx=%0d max=%0d mg=%0d, required 1 0 0 0 0",
               in_ready, out_valid, class_idx, max_val, margin);
    end
    bad = 0;
    repeat (15) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b0) bad++;
    end
    n_tests++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL midscan_no_result: out_valid high %0d cycles, required 0", bad);
    end
    send_frame(mk10(0, 0, 0, 0, 0, 0, 0, 0, 50, 49), lat, cc);
    n_tests++;
    if (lat != 10 || {class_idx, max_val, margin, no_detect} !== {4'd8, 8'd50, 8'd1, 1'b0}) begin
      n_fail++;
      $display("FAIL midscan_next_frame: lat=%0d idx=%0d max=%0d mg=%0d, required 10 8 50 1",
               lat, class_idx, max_val, margin);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    int         lat, cc, prev;
    frame_t     f;
    logic [3:0] ei;
    logic [7:0] em, eg;
    logic       en;
    out_ready = 1'b1;
    prev = -1;
    for (int k = 0; k < 4; k++) begin
      f = rand_frame(k[0] ? 15 : 255);
      ref_model(f, ei, em, eg, en);
      send_frame(f, lat, cc);
      n_tests++;
      if (lat != 10 || (prev >= 0 && cc - prev != 11) ||
          {class_idx, max_val, margin, no_detect} !== {ei, em, eg, en}) begin
        n_fail++;
        $display("FAIL b2b_frame%0d: lat=%0d period=%0d idx=%0d max=%0d mg=%0d nd=%b, required 10 11 %0d %0d %0d %b",
                 k, lat, cc - prev, class_idx, max_val, margin, no_detect, ei, em, eg, en);
      end
      prev = cc;
    end
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    int         lat, cc, d;
    frame_t     f;
    logic [3:0] ei;
    logic [7:0] em, eg;
    logic       en;
    for (int k = 0; k < 40; k++) begin
      out_ready = 1'b0;
      case (k % 4)
        0:       f = rand_frame(255);
        1:       f = rand_frame(3);
        2:       f = rand_frame(127);
        default: f = rand_frame(1);
      endcase
      ref_model(f, ei, em, eg, en);
      send_frame(f, lat, cc);
      n_tests++;
      if (lat != 10 || {class_idx, max_val, margin, no_detect} !== {ei, em, eg, en}) begin
        n_fail++;
        $display("FAIL rand_frame%0d: lat=%0d idx=%0d max=%0d mg=%0d nd=%b, required 10 %0d %0d %0d %b",
                 k, lat, class_idx, max_val, margin, no_detect, ei, em, eg, en);
      end
      d = $urandom_range(0, 3);
      repeat (d) begin
        @(posedge clk); #1;
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      n_tests++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL rand_consume%0d: ov=%b rdy=%b, required 0 1", k, out_valid, in_ready);
      end
    end
  endtask

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    for (int i = 0; i < 10; i++) n[i] = 8'd0;
    test_reset();
    test_distinct();
    test_ties();
    test_all_zero();
    test_backpressure();
    test_reset_mid_scan();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/layer3_argmax_classifier.md
Name: layer3_argmax_classifier

Overview:
- Terminal stage of the ECG MLP datapath; sits directly downstream of the ten layer-3 output nodes.
- Captures the ten ReLU-clamped node outputs N0x..N9x as one frame on a valid/ready handshake.
- Scans the frame sequentially, one element per cycle, and reports:
  - the winning class index;
  - its activation value;
  - its margin over the runner-up;
  - a no-detect flag when every activation is zero.

Parameters:
- N_IN, 10, number of node outputs per frame (fixed at 10 for layer 3).
- DW, 8, width of each node output.
- IDXW, 4, width of the class index (must satisfy 2^IDXW >= N_IN).

Ports:
- clk  input  1  system clock, all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- N0x..N9x  input  8 each  layer-3 node outputs, treated as unsigned (ReLU guarantees bit 7 = 0, but compares are unsigned over all 8 bits).
- in_valid  input  1  frame on N0x..N9x is valid this cycle.
- in_ready  output  1  block can accept a frame; high only in IDLE.
- out_valid  output  1  result fields valid; held until consumed.
- out_ready  input  1  downstream consumes the result.
- class_idx  output  IDXW  index of the maximum activation.
- max_val  output  DW  value of the maximum activation.
- margin  output  DW  max_val minus second-highest activation (unsigned, never negative).
- no_detect  output  1  high when max_val == 0.

Behaviour:
- Registers:
  - cap[0..9]: captured frame;
  - cnt: 4-bit scan pointer;
  - best, second, best_idx.
- State machine states: IDLE, SCAN, DONE.
- Reset (synchronous, checked before any other action on the edge):
  - state = IDLE; cnt = 0;
  - best, second, best_idx, cap[] = 0;
  - out_valid = 0, class_idx = 0, max_val = 0, margin = 0, no_detect = 0.
  - Reset mid-SCAN or in DONE aborts the frame; no result is emitted.
- in_ready is combinational: (state == IDLE). It is therefore high in the first cycle after reset is released.
- IDLE:
  - When in_valid && in_ready, on that edge: cap[i] <= Ni x; best <= N0x; best_idx <= 0; second <= 0; cnt <= 1; state <= SCAN.
  - When in_valid is low, the block holds.
- SCAN: on each cycle, with x = cap[cnt]:
  - If x > best (strict): second <= best; best <= x; best_idx <= cnt.
  - Else if x > second: second <= x.
  - cnt <= cnt + 1.
  - When cnt == N_IN-1 is being processed: state <= DONE; cnt <= 0.
  - SCAN lasts exactly N_IN-1 = 9 cycles.
  - Ties go to the lowest index. An equal value updates second, so the margin becomes 0.
- DONE:
  - out_valid = 1; class_idx = best_idx; max_val = best; margin = best - second; no_detect = (best == 0).
  - All outputs are registered and stable while out_valid && !out_ready.
  - On out_valid && out_ready: out_valid <= 0 and state <= IDLE. Result fields keep their last values.
- Latency: a frame accepted at the edge ending cycle T gives out_valid high from cycle T+10.
  - Minimum frame period is 11 cycles when out_ready is held high. The next frame is accepted in the cycle after the handshake.
- in_valid while not in IDLE is ignored; the upstream frame is not consumed.
- out_ready asserted while out_valid is low has no effect.
- Inputs are sampled only at the capture edge. Changes on N*x during SCAN/DONE do not affect the result.

Test Plan:
- Reset release:
  - Required: in_ready = 1, out_valid = 0, all result fields 0.
  - Assert reset while in_valid = 1: no capture occurs.
- Distinct maximum:
  - Stimulus: frame {3,10,7,0,2,5,1,9,4,6}, out_ready = 1.
  - Required: out_valid exactly 10 cycles after capture; class_idx = 1, max_val = 10, margin = 1, no_detect = 0; in_ready high again the next cycle.
- Tie handling:
  - Stimulus: frame {5,20,3,20,0,0,0,0,0,0}.
  - Required: class_idx = 1, max_val = 20, margin = 0.
  - Stimulus: frame with max only at index 9 = 127, others 0.
  - Required: class_idx = 9, margin = 127.
- All-zero frame:
  - Required: class_idx = 0, max_val = 0, margin = 0, no_detect = 1.
- Backpressure:
  - Stimulus: hold out_ready = 0 for 5 cycles after out_valid; toggle N*x and pulse in_valid meanwhile.
  - Required: outputs stable, in_ready = 0, no new capture. Handshake completes in the cycle out_ready rises; the next frame is accepted on the following cycle.
- Reset mid-scan:
  - Stimulus: assert reset 4 cycles into SCAN.
  - Required: out_valid never rises for that frame; state returns to IDLE. A subsequent frame {0,0,0,0,0,0,0,0,50,49} yields class_idx = 8, max_val = 50, margin = 1.
